// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   op_t     : operation encodings carried on the 2-bit op port
//   state_t  : sequencer states
//   DZ_QUOT  : quotient written to LO on divide by zero
//   neg32    : two's-complement negate
//   mag32    : magnitude of a value, treated as signed only when sgn is set
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/adderc.sv
// Carry-in/carry-out ripple adder.
//   a, b : addends
//   cin  : carry in
//   s    : sum
//   cout : carry out
module adderc #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign s    = full[WIDTH-1:0];
    assign cout = full[WIDTH];

endmodule

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the shift-add multiplier or restoring divider,
// sharing a single 33-bit adder.
//   acc_hi, acc_lo : current accumulator (P_hi/P_lo or R/Q)
//   operand        : |multiplicand| for multiply, |divisor| for divide
//   mode           : 0 multiply, 1 divide
//   next_hi/lo     : accumulator after this iteration
module muldiv_step (
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
    input  logic [31:0] operand,
    input  logic        mode,
    output logic [31:0] next_hi,
    output logic [31:0] next_lo
);

    logic [32:0] add_a;
    logic [32:0] add_b;
    logic [32:0] add_s;
    logic        add_cin;
    logic        add_cout;
    logic [32:0] sel;

    adderc #(.WIDTH(33)) u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        add_a   = {1'b0, acc_hi};
        add_b   = {1'b0, operand};
        add_cin = 1'b0;
        sel     = add_a;
        next_hi = acc_hi;
        next_lo = acc_lo;
        if (mode) begin
            // Shifted remainder is 33 bits wide; carry out of R + ~D + 1
            // means no borrow, i.e. the trial difference is non-negative.
            add_a   = {acc_hi, acc_lo[31]};
            add_b   = ~{1'b0, operand};
            add_cin = 1'b1;
            next_hi = add_cout ? add_s[31:0] : add_a[31:0];
            next_lo = {acc_lo[30:0], add_cout};
        end else begin
            sel     = acc_lo[0] ? add_s : add_a;
            next_hi = sel[32:1];
            next_lo = {sel[0], acc_lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
//   clk, reset   : clock, asynchronous active-high reset
//   start, op    : launch an operation (sampled in IDLE only)
//   srca, srcb   : rs / rt operands
//   cancel       : abort the running operation, HI/LO untouched
//   mthi, mtlo   : write srca into HI / LO while idle
//   busy, done   : operation in flight / one-cycle completion pulse
//   hi, lo       : architectural HI and LO
//
// state | meaning
// IDLE  | waiting; accepts start and mthi/mtlo
// RUN   | one multiply/divide iteration per cycle, ITERS cycles
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        cancel,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t      state, state_next;
    logic [CW-1:0] count;
    op_t         op_q;
    logic [31:0] opnd;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] a_raw;
    logic        neg_q;
    logic        neg_r;
    logic        dz;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic        launch;
    logic        mt_ok;
    logic        write_res;
    logic [63:0] product;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign launch    = (state == IDLE) && start && !cancel;
    assign mt_ok     = (state == IDLE) && !start;
    assign write_res = (state == FIX) && !cancel;
    assign busy      = (state != IDLE);
    assign a_mag     = mag32(srca, op[0]);
    assign b_mag     = mag32(srcb, op[0]);

    muldiv_step u_step (
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (opnd),
        .mode    (op_q[1]),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !cancel) state_next = RUN;
            RUN:     if (cancel) state_next = IDLE;
                     else if (count == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            op_q   <= OP_MULTU;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            a_raw  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (launch) begin
            count  <= '0;
            op_q   <= op_t'(op);
            opnd   <= op[1] ? b_mag : a_mag;
            acc_hi <= '0;
            acc_lo <= op[1] ? a_mag : b_mag;
            a_raw  <= srca;
            neg_q  <= srca[31] ^ srcb[31];
            neg_r  <= srca[31];
            dz     <= op[1] && (srcb == 32'd0);
        end else if (state == RUN && !cancel) begin
            count  <= count + 1'b1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    // Result fix-up; the magnitudes in the accumulator are only negated for
    // the signed opcodes. Divide by zero overrides with the raw dividend.
    always_comb begin
        product = {acc_hi, acc_lo};
        res_hi  = acc_hi;
        res_lo  = acc_lo;
        if (!op_q[1]) begin
            if (op_q == OP_MULT && neg_q) product = ~product + 64'd1;
            res_hi = product[63:32];
            res_lo = product[31:0];
        end else if (dz) begin
            res_hi = a_raw;
            res_lo = DZ_QUOT;
        end else if (op_q == OP_DIV) begin
            res_lo = neg_q ? neg32(acc_lo) : acc_lo;
            res_hi = neg_r ? neg32(acc_hi) : acc_hi;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= write_res;
            if (write_res) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (mt_ok) begin
                if (mthi) hi <= srca;
                if (mtlo) lo <= srca;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected HI/LO and the
// start cycle; a monitor pops and checks on every done pulse.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        cancel = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          c0;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    muldiv_seq #(.ITERS(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .cancel (cancel),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("hi", {32'd0, hi}, {32'd0, e.hi});
                chk("lo", {32'd0, lo}, {32'd0, e.lo});
                chk("latency", 64'(cyc - e.c0), 64'd33);
                chk("done_width", {63'd0, prev_done}, 64'd0);
                chk("busy_at_done", {63'd0, busy}, 64'd0);
            end
        end
        prev_done <= done;
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int c0);
        @(negedge clk);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("timeout", 64'd1, 64'd0);
        @(negedge clk);
        chk("done_dropped", {63'd0, done}, 64'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int c0;
        exp_t e;
        launch(o, a, b, c0);
        e.hi = eh;
        e.lo = el;
        e.c0 = c0;
        exp_q.push_back(e);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        wait_idle(40);
    endtask

    initial begin
        int c0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        run_op(OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // MTHI, MTLO, then both together
        @(negedge clk); srca = 32'h0000_AAAA; mthi = 1'b1;
        @(negedge clk); mthi = 1'b0; srca = 32'h0000_5555; mtlo = 1'b1;
        @(negedge clk); mtlo = 1'b0;
        chk("mthi", {32'd0, hi}, 64'h0000_AAAA);
        chk("mtlo", {32'd0, lo}, 64'h0000_5555);
        srca = 32'h0000_1111; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both", {hi, lo}, 64'h0000_1111_0000_1111);
        srca = 32'h0000_AAAA; mthi = 1'b1;
        @(negedge clk); mthi = 1'b0; srca = 32'h0000_5555; mtlo = 1'b1;
        @(negedge clk); mtlo = 1'b0;

        // start with a same-cycle mthi: write is dropped; stray start at E5;
        // cancel sampled at E10
        @(negedge clk);
        op = OP_MULT; srca = 32'd7; srcb = 32'd9; start = 1'b1; mthi = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        chk("cancel_busy_on", {63'd0, busy}, 64'd1);
        repeat (4) @(posedge clk);
        @(negedge clk); start = 1'b1; op = OP_DIVU; srca = 32'h1; srcb = 32'h1;
        @(posedge clk); #1; start = 1'b0;
        chk("mthi_dropped", {32'd0, hi}, 64'h0000_AAAA);
        repeat (4) @(posedge clk);
        @(negedge clk); cancel = 1'b1;
        @(posedge clk); #1; cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", {63'd0, busy}, 64'd0);
        chk("cancel_done", {63'd0, done}, 64'd0);
        chk("cancel_hilo", {hi, lo}, 64'h0000_AAAA_0000_5555);
        repeat (40) @(negedge clk);
        chk("cancel_idle", {63'd0, busy}, 64'd0);
        chk("cancel_hilo_later", {hi, lo}, 64'h0000_AAAA_0000_5555);

        // reset in the middle of a DIVU
        launch(OP_DIVU, 32'd1000, 32'd3, c0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
